// File: rtl/tdm_demux4_rx.sv
// -----------------------------------------------------------------------------
// tdm_demux4_rx
//
// Receive end of a four-slot TDM serial link. The block locks onto the
// one-slot frame marker, deserialises each frame (slot 0..3 = channel a..d)
// and presents the four channel bits in parallel with a one-cycle strobe.
//
// Parameters:
//   LOCK_FRAMES  consecutive correctly placed markers needed to lock (1..7)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   en           slot strobe: one slot is consumed per cycle with en=1
//   din          serial data bit of the current slot
//   fsync        frame marker, 1 on slot 0 (only meaningful with en=1)
//   a,b,c,d      channel bits of the last delivered frame (registered)
//   frame_valid  one-cycle pulse when a..d update
//   locked       1 while the FSM is in LOCKED
//   sync_err     one-cycle pulse on loss of frame alignment
//   dbg_state    {fsm state (1 = LOCKED), good_cnt} for observation
//
// Handshake: there is no back-pressure. A slot is transferred on every rising
// edge where en=1; cycles with en=0 change nothing except the pulse outputs.
// -----------------------------------------------------------------------------
module tdm_demux4_rx #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       din,
  input  logic       fsync,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err,
  output logic [3:0] dbg_state
);

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_FRAMES);

  state_t      r_state;
  logic [1:0]  r_slot;
  logic [2:0]  r_good_cnt;
  logic [2:0]  r_sh;
  logic        r_a, r_b, r_c, r_d;
  logic        r_frame_valid;
  logic        r_sync_err;

  state_t      w_state_nxt;
  logic [2:0]  w_good_nxt;
  logic [2:0]  w_good_inc;
  logic        w_accept;
  logic [1:0]  w_idx;
  logic        w_update;
  logic        w_err;

  assign w_good_inc = r_good_cnt + 3'd1;

  // Next-state decode. A marker always forces the accepted slot index to 0,
  // which is how realignment and the first frame after HUNT both work.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_accept    = 1'b0;
    w_idx       = fsync ? 2'd0 : r_slot;
    w_update    = 1'b0;
    w_err       = 1'b0;
    if (en) begin
      case (r_state)
        ST_HUNT: begin
          if (r_good_cnt == 3'd0) begin
            // Idle: wait for any marker; everything else is discarded.
            if (fsync) begin
              w_accept   = 1'b1;
              w_good_nxt = 3'd1;
              if (LOCK_CNT <= 3'd1) w_state_nxt = ST_LOCKED;
            end
          end else if (fsync) begin
            w_accept = 1'b1;
            if (r_slot == 2'd0) begin
              w_good_nxt = w_good_inc;
              if (w_good_inc >= LOCK_CNT) w_state_nxt = ST_LOCKED;
            end else begin
              // Marker in the wrong place: restart counting from this frame.
              w_good_nxt = 3'd1;
              if (LOCK_CNT <= 3'd1) w_state_nxt = ST_LOCKED;
            end
          end else if (r_slot == 2'd0) begin
            // Expected marker missing.
            w_good_nxt = 3'd0;
          end else begin
            w_accept = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (fsync) begin
            w_accept = 1'b1;
            if (r_slot != 2'd0) begin
              w_err       = 1'b1;
              w_state_nxt = ST_HUNT;
              w_good_nxt  = 3'd1;
            end
          end else if (r_slot == 2'd0) begin
            w_err       = 1'b1;
            w_state_nxt = ST_HUNT;
            w_good_nxt  = 3'd0;
          end else begin
            w_accept = 1'b1;
            // Slot 3 can only be reached without a marker, so a frame that
            // ended in an error never gets here.
            if (r_slot == 2'd3) w_update = 1'b1;
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_HUNT;
      r_slot        <= 2'd0;
      r_good_cnt    <= 3'd0;
      r_sh          <= 3'd0;
      r_a           <= 1'b0;
      r_b           <= 1'b0;
      r_c           <= 1'b0;
      r_d           <= 1'b0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_good_cnt    <= w_good_nxt;
      r_frame_valid <= w_update;
      r_sync_err    <= w_err;
      if (w_accept) begin
        if (w_idx == 2'd3) begin
          r_slot <= 2'd0;
        end else begin
          r_sh[w_idx] <= din;
          r_slot      <= w_idx + 2'd1;
        end
      end
      if (w_update) begin
        r_a <= r_sh[0];
        r_b <= r_sh[1];
        r_c <= r_sh[2];
        r_d <= din;
      end
    end
  end

  assign a           = r_a;
  assign b           = r_b;
  assign c           = r_c;
  assign d           = r_d;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign locked      = (r_state == ST_LOCKED);
  assign dbg_state   = {r_state, r_good_cnt};

endmodule

// File: tb/tb_tdm_demux4_rx.sv
module tb_tdm_demux4_rx;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       din;
  logic       fsync;
  logic       a, b, c, d;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic [3:0] dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  localparam logic ST_HUNT   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  tdm_demux4_rx #(.LOCK_FRAMES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .din         (din),
    .fsync       (fsync),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err),
    .dbg_state   (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver: apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic e, input logic f, input logic dd);
    en    = e;
    fsync = f;
    din   = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Compares {a,b,c,d,frame_valid,locked,sync_err} in one go.
  task automatic chk_o(input string tag, input logic [3:0] exp_abcd,
                       input logic exp_fv, input logic exp_lk, input logic exp_se);
    chk(tag, {1'b0, a, b, c, d, frame_valid, locked, sync_err},
             {1'b0, exp_abcd, exp_fv, exp_lk, exp_se});
  endtask

  task automatic chk_st(input string tag, input logic exp_st, input logic [2:0] exp_cnt);
    chk(tag, {4'b0, dbg_state}, {4'b0, exp_st, exp_cnt});
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    fsync = 1'b0;

    // Reset values with random inputs
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk_o("reset_out", 4'b0000, 1'b0, 1'b0, 1'b0);
      chk_st("reset_st", ST_HUNT, 3'd0);
    end
    rst_n = 1'b1;

    // Lock and deliver: frames 1010, 0110, 1111
    step(1, 1, 1);
    chk_st("f1_s0_cnt", ST_HUNT, 3'd1);
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 0);
    chk_o("f1_not_delivered", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1, 1, 0);
    chk_o("lock_f2_s0", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1, 0, 1); step(1, 0, 1);
    chk_o("f2_s2_no_fv", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0);
    chk_o("deliver_f2", 4'b0110, 1'b1, 1'b1, 1'b0);
    step(1, 1, 1);
    chk_o("fv_one_cycle", 4'b0110, 1'b0, 1'b1, 1'b0);
    step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
    chk_o("deliver_f3", 4'b1111, 1'b1, 1'b1, 1'b0);

    // Gapped en: frame 0101 with gaps 0/1/3, fsync toggling in gaps
    step(1, 1, 0);
    step(1, 0, 1);
    step(0, 1, 0);
    chk_o("gap1", 4'b1111, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0);
    step(0, 1, 1); step(0, 0, 0); step(0, 1, 1);
    chk_o("gap3", 4'b1111, 1'b0, 1'b1, 1'b0);
    step(1, 0, 1);
    chk_o("deliver_gap", 4'b0101, 1'b1, 1'b1, 1'b0);

    // Misplaced fsync at slot 2
    step(1, 1, 0); step(1, 0, 0);
    step(1, 1, 1);
    chk_o("mis_err", 4'b0101, 1'b0, 1'b0, 1'b1);
    chk_st("mis_st", ST_HUNT, 3'd1);
    step(1, 0, 1);
    chk_o("mis_err_pulse", 4'b0101, 1'b0, 1'b0, 1'b0);
    step(1, 0, 1); step(1, 0, 0);
    chk_o("mis_no_deliver", 4'b0101, 1'b0, 1'b0, 1'b0);
    step(1, 1, 1);
    chk_o("relock", 4'b0101, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 1);
    chk_o("relock_deliver", 4'b1001, 1'b1, 1'b1, 1'b0);

    // Missing fsync at slot 0
    step(1, 0, 1);
    chk_o("miss_err", 4'b1001, 1'b0, 1'b0, 1'b1);
    chk_st("miss_st", ST_HUNT, 3'd0);
    step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    chk_o("miss_discard", 4'b1001, 1'b0, 1'b0, 1'b0);
    chk_st("miss_idle", ST_HUNT, 3'd0);
    step(1, 1, 0);
    chk_st("miss_hunt1", ST_HUNT, 3'd1);
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
    chk_o("miss_hunt_nofv", 4'b1001, 1'b0, 1'b0, 1'b0);
    step(1, 1, 0);
    chk_st("miss_relock_st", ST_LOCKED, 3'd2);
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 1);
    chk_o("miss_deliver", 4'b0011, 1'b1, 1'b1, 1'b0);

    // Reset mid-frame at slot 2
    step(1, 1, 1); step(1, 0, 1);
    rst_n = 1'b0;
    step(1, 0, 1);
    chk_o("rst_mid_out", 4'b0000, 1'b0, 1'b0, 1'b0);
    chk_st("rst_mid_st", ST_HUNT, 3'd0);
    rst_n = 1'b1;
    step(1, 0, 0);
    chk_o("rst_tail_discard", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1, 1, 1); step(1, 0, 1); step(1, 0, 1); step(1, 0, 1);
    chk_o("rst_first_frame", 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1, 1, 1);
    chk_o("rst_relock", 4'b0000, 1'b0, 1'b1, 1'b0);
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 0);
    chk_o("rst_deliver", 4'b1010, 1'b1, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tdm_demux4_rx.md
# tdm_demux4_rx

Four-channel time-division demultiplexer: the receive end of the 4:1 slice-based TDM link. A serial stream in which each frame is four slots (slot 0..3 carrying channels a..d) arrives on `din` with a one-slot frame marker. The block locks to the marker, deserialises each frame, and presents the four channel bits in parallel with a one-cycle frame strobe. It sits between the board-level serial input and the per-channel consumer logic.

## Interface

Parameters:
- `LOCK_FRAMES`, default 2: number of consecutive correctly placed frame markers needed to enter LOCKED. Legal range is 1..7.

Ports:
- `clk` input 1: the single clock; everything samples on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `en` input 1: slot strobe; one slot is consumed per cycle with `en`=1.
- `din` input 1: serial data bit for the current slot.
- `fsync` input 1: frame marker, 1 on slot 0 of each frame; only meaningful when `en`=1.
- `a`, `b`, `c`, `d` output 1 each: channel bits of the last delivered frame, registered.
- `frame_valid` output 1: one-cycle pulse when a..d update.
- `locked` output 1: 1 while the FSM is in LOCKED.
- `sync_err` output 1: one-cycle pulse on loss of frame alignment.

## Operation

Internal state:
- `slot` is a 2-bit counter that wraps 3->0.
- `good_cnt` is a 3-bit counter.
- `sh0..sh2` are shadow bits.
- The FSM has two states, HUNT and LOCKED.

General rules:
- Cycles with `en`=0 change nothing except clearing the pulse outputs. `fsync` and `din` are ignored in those cycles.
- Every `en` cycle that is accepted as slot k (k = 0..2) writes `sh<k> <= din`, then `slot <= k+1`.
- An `en` cycle accepted as slot 3 sets `slot <= 0`. If the FSM is LOCKED at that edge, the same edge performs the frame update: `a<=sh0`, `b<=sh1`, `c<=sh2`, `d<=din`, `frame_valid<=1`.

HUNT, with `good_cnt`=0 (idle):
- `en`=1 and `fsync`=0: discarded.
- `en`=1 and `fsync`=1: accepted as slot 0, `good_cnt<=1`.

HUNT, with `good_cnt`≥1 (counting):
- `fsync`=1 at `slot`=0: accepted, `good_cnt<=good_cnt+1`. If the new value equals `LOCK_FRAMES`, the FSM moves to LOCKED and `locked<=1` on the same edge.
- `fsync`=1 at `slot`≠0: realign. The bit is accepted as slot 0 and `good_cnt<=1`.
- `fsync`=0 at `slot`=0: marker missing. The bit is discarded and `good_cnt<=0`.
- Special case `LOCK_FRAMES`=1: the first accepted `fsync` enters LOCKED directly.

LOCKED:
- `fsync`=1 at `slot`=0: normal; the bit is accepted.
- `fsync`=1 at `slot`≠0: `sync_err<=1` and the FSM returns to HUNT. The bit is accepted as slot 0 and `good_cnt<=1`. The partial frame is dropped (no update).
- `fsync`=0 at `slot`=0: `sync_err<=1`, the FSM returns to HUNT, `good_cnt<=0`, and the bit is discarded.
- `locked` clears on the same edge in both error cases.

Common rules:
- a..d hold their last delivered values through HUNT and through errors.
- The shadow bits of a dropped frame are never delivered.

## Timing

- Reset: if `rst_n`=0 at an edge, then on that edge a, b, c, d, `frame_valid`, `locked`, `sync_err`, `slot`, `good_cnt` and `sh0..sh2` all go to 0 and the FSM goes to HUNT. Reset overrides `en`.
- Reset asserted mid-frame discards the frame. The first frame after reset needs a fresh `fsync`.
- Latency: a..d become visible the cycle after the slot-3 sampling edge. `d` has 1-cycle latency from its own sample; `a` has latency of (distance to the slot-3 `en` edge) + 1.
- `frame_valid` and `sync_err` are high for exactly one cycle and are never high in the same cycle.
- Lock time with back-to-back `en`:
  - `locked` rises at the edge sampling the `LOCK_FRAMES`-th correct `fsync`.
  - With `LOCK_FRAMES`=2, that is the edge of the frame-2 slot 0.
  - The first `frame_valid` follows 3 cycles later.
- Sustained rate: one frame per 4 `en` cycles. `en` may have arbitrary gaps; slot positions count only `en` cycles.

## Test plan

- **Reset values:** hold `rst_n`=0 for 3 cycles with random `din`/`fsync`/`en` -> all outputs 0, `locked`=0.
- **Lock and deliver:** `LOCK_FRAMES`=2, `en`=1 continuously, frames 1010, 0110, 1111 (slot 0 first, `fsync` on slot 0).
  - `locked`=1 after the frame-2 slot-0 edge; frame 1 is not delivered.
  - `frame_valid` pulses after frame-2 slot 3 with a,b,c,d=0,1,1,0.
  - `frame_valid` pulses again 4 cycles later with 1,1,1,1.
- **Gapped `en`:** when locked, insert `en`=0 gaps of 0/1/3 cycles between slots of frame 0101 -> a..d=0,1,0,1 with one `frame_valid`; `fsync` toggled during gaps is ignored.
- **Misplaced `fsync`:** when locked, assert `fsync` at slot 2 -> `sync_err` pulse, `locked`=0, no `frame_valid` for that frame, a..d hold their old values. Two further aligned frames -> relock, then delivery.
- **Missing `fsync`:** when locked, slot 0 arrives with `fsync`=0 -> `sync_err`=1 for one cycle, HUNT with `good_cnt`=0, and `en` cycles are discarded until the next `fsync`.
- **Reset mid-frame:** assert `rst_n`=0 at slot 2 of a locked frame -> outputs 0 the next cycle; after release, no `frame_valid` until a new lock sequence completes.
